bin2therm_dwa: RTL and testbench
================================

BIN2THERM_DWA -- requirements
Module: bin2therm_dwa

Interface
REQ-001 The module SHALL have parameter NBITS, default 4, giving the binary input width (legal 2..8).
REQ-002 The module SHALL have parameter INVERT, default 1: 1 = code 0 gives all ones and the all-ones code gives zero; 0 = straight count.
REQ-003 The module SHALL derive local parameter TW = 2**NBITS - 1, the thermometer width.
REQ-004 clk  input  1  Single clock; all state updates on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-high reset.
REQ-006 in_valid  input  1  binary_in is sampled this cycle.
REQ-007 binary_in  input  NBITS  Binary code to decode.
REQ-008 mode  input  1  0 = static thermometer; 1 = data-weighted-averaging (DWA) rotation.
REQ-009 ptr_clear  input  1  Synchronous clear of the rotation pointer.
REQ-010 therm_out  output  TW  Registered thermometer or rotated unit-element selection.
REQ-011 out_valid  output  1  therm_out was updated on the previous edge.
REQ-012 ptr_out  output  NBITS  Current rotation pointer, range 0..TW-1.

Function
REQ-013 The block SHALL compute the ones count k = TW - binary_in when INVERT=1, else k = binary_in; k range is 0..TW.
REQ-014 On an edge with in_valid=1, therm_out SHALL load the new pattern; out_valid SHALL be 1 on the following cycle, giving a latency of 1 clock.
REQ-015 On an edge with in_valid=0, therm_out and the pointer SHALL hold, and out_valid SHALL go to 0.
REQ-016 In static mode (mode=0), the pattern SHALL be therm_out[i]=1 for i<k, else 0; the pointer SHALL be left unchanged.
REQ-017 In DWA mode (mode=1), the pattern SHALL set ones at indices (ptr+j) mod TW for j=0..k-1, and all other bits SHALL be 0.
REQ-018 In DWA mode, on each accepted sample the pointer SHALL update to (ptr+k) mod TW; the sum SHALL be computed at NBITS+1 bits before the modulo.
REQ-019 Wrap-around: a run of ones crossing index TW-1 SHALL continue at index 0.
REQ-020 k=TW SHALL give all ones with the pointer unchanged; k=0 SHALL give all zeros with the pointer unchanged.
REQ-021 ptr_clear=1 with in_valid=0 SHALL set the pointer to 0 on that edge.
REQ-022 ptr_clear=1 with in_valid=1 in DWA mode SHALL decode using pointer 0, and the pointer SHALL become k mod TW.
REQ-023 ptr_clear=1 with in_valid=1 in static mode SHALL produce the static pattern, and the pointer SHALL become 0.
REQ-024 A mode change SHALL take effect on the next accepted sample; switching modes SHALL NOT alter the pointer except through ptr_clear.
REQ-025 ptr_out SHALL reflect the registered pointer value, i.e. the value after the most recent edge.
REQ-026 An out-of-range binary_in cannot occur, since every NBITS code maps to 0..TW; no default fallback is required.

Reset
REQ-027 While reset=1, therm_out SHALL be 0, out_valid SHALL be 0 and the pointer SHALL be 0, immediately and independent of clk.
REQ-028 Reset asserted mid-stream SHALL discard the in-flight sample, and no out_valid pulse SHALL follow.
REQ-029 After reset deasserts, the first edge with in_valid=1 SHALL decode using pointer 0.

Verification (NBITS=4, INVERT=1, TW=15)
REQ-030 Static sweep: mode=0, binary_in F,E,...,0 on consecutive valid cycles -> therm_out 0x0000,0x0001,0x0003,...,0x7FFF one cycle later; ptr_out stays 0.
REQ-031 DWA wrap: ptr 0, binary_in A (k=5) -> 0x001F, ptr 5; then binary_in 3 (k=12) -> 0x7FE3, ptr 2.
REQ-032 DWA extremes: ptr 7, binary_in 0 (k=15) -> 0x7FFF, ptr 7; then binary_in F (k=0) -> 0x0000, ptr 7.
REQ-033 Clear collision: ptr 9, ptr_clear=1 with in_valid=1 and binary_in C (k=3) -> 0x0007, ptr 3.
REQ-034 Hold: in_valid=0 for 3 cycles after a valid sample -> therm_out and ptr_out unchanged, out_valid 0.
REQ-035 Async reset mid-run: assert reset between edges with ptr 11 -> therm_out 0, out_valid 0, ptr_out 0 before the next edge.

Source files
------------

// File: rtl/bin2therm_dwa.sv
// bin2therm_dwa
// Binary-to-thermometer decoder for a unit-element DAC, with an optional
// data-weighted-averaging (DWA) mode that rotates the selected elements
// around a circular pointer so that element mismatch is first-order shaped.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   in_valid   : binary_in is sampled on this edge
//   binary_in  : NBITS-wide code to decode
//   mode       : 0 = static thermometer, 1 = DWA rotation
//   ptr_clear  : synchronous clear of the rotation pointer
//   therm_out  : registered unit-element selection, TW bits
//   out_valid  : therm_out was loaded on the previous edge
//   ptr_out    : registered rotation pointer, 0..TW-1
module bin2therm_dwa #(
    parameter int NBITS  = 4,
    parameter bit INVERT = 1'b1,
    localparam int TW    = 2**NBITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [NBITS-1:0] binary_in,
    input  logic             mode,
    input  logic             ptr_clear,
    output logic [TW-1:0]    therm_out,
    output logic             out_valid,
    output logic [NBITS-1:0] ptr_out
);

    logic [TW-1:0]    therm_q, therm_d;
    logic             valid_q, valid_d;
    logic [NBITS-1:0] ptr_q, ptr_d;

    logic [NBITS-1:0] k;
    logic [NBITS-1:0] ptr_base;
    logic [TW-1:0]    mask;
    logic [2*TW-1:0]  rot_wide;
    logic [TW-1:0]    rot;
    logic [NBITS:0]   ptr_sum;
    logic [NBITS:0]   ptr_sum_wrap;
    logic [NBITS-1:0] ptr_adv;

    // TW is all ones in NBITS bits, so the subtraction never underflows.
    assign k = INVERT ? (NBITS'(TW) - binary_in) : binary_in;

    // A clear that coincides with a sample decodes from pointer 0.
    assign ptr_base = ptr_clear ? '0 : ptr_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < TW; i++) begin
            if (i < int'(k)) begin
                mask[i] = 1'b1;
            end
        end
    end

    // Circular rotate by ptr_base: bits shifted past TW-1 land in the upper
    // half and are folded back onto index 0 onward.
    assign rot_wide = {{TW{1'b0}}, mask} << ptr_base;
    assign rot      = rot_wide[TW-1:0] | rot_wide[2*TW-1:TW];

    // ptr_base <= TW-1 and k <= TW, so one conditional subtract is a full
    // modulo-TW reduction. k = TW therefore leaves the pointer where it was.
    assign ptr_sum      = {1'b0, ptr_base} + {1'b0, k};
    assign ptr_sum_wrap = ptr_sum - (NBITS+1)'(TW);
    assign ptr_adv      = (ptr_sum >= (NBITS+1)'(TW)) ? ptr_sum_wrap[NBITS-1:0]
                                                      : ptr_sum[NBITS-1:0];

    always_comb begin
        therm_d = therm_q;
        valid_d = 1'b0;
        ptr_d   = ptr_clear ? '0 : ptr_q;
        if (in_valid) begin
            valid_d = 1'b1;
            if (mode) begin
                therm_d = rot;
                ptr_d   = ptr_adv;
            end else begin
                therm_d = mask;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            therm_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            therm_q <= therm_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign therm_out = therm_q;
    assign out_valid = valid_q;
    assign ptr_out   = ptr_q;

endmodule

// File: tb/tb_bin2therm_dwa.sv
module tb_bin2therm_dwa;

    localparam int NBITS = 4;
    localparam int TW    = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [NBITS-1:0] binary_in;
    logic             mode;
    logic             ptr_clear;
    logic [TW-1:0]    therm_out;
    logic             out_valid;
    logic [NBITS-1:0] ptr_out;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int            m_ptr   = 0;
    logic [TW-1:0] m_therm = '0;
    logic          m_valid = 1'b0;

    bin2therm_dwa #(.NBITS(NBITS), .INVERT(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .binary_in(binary_in),
        .mode     (mode),
        .ptr_clear(ptr_clear),
        .therm_out(therm_out),
        .out_valid(out_valid),
        .ptr_out  (ptr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".therm"}, 32'(therm_out), 32'(m_therm));
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".ptr"},   32'(ptr_out),   32'(m_ptr));
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare 1 ns later.
    task automatic step(input logic v, input logic [3:0] b, input logic md,
                        input logic clr, input string tag);
        int k;
        int base;
        logic [TW-1:0] p;
        @(negedge clk);
        in_valid  = v;
        binary_in = b;
        mode      = md;
        ptr_clear = clr;
        @(posedge clk);
        #1;
        if (v) begin
            k    = TW - int'(b);
            base = clr ? 0 : m_ptr;
            p    = '0;
            for (int j = 0; j < k; j++) begin
                if (md) p[(base + j) % TW] = 1'b1;
                else    p[j] = 1'b1;
            end
            m_therm = p;
            m_valid = 1'b1;
            m_ptr   = md ? (base + k) % TW : base;
        end else begin
            m_valid = 1'b0;
            if (clr) m_ptr = 0;
        end
        check_model(tag);
    endtask

    initial begin
        logic [TW-1:0] hold_therm;
        logic [3:0]    hold_ptr;

        reset     = 1'b1;
        in_valid  = 1'b0;
        binary_in = '0;
        mode      = 1'b0;
        ptr_clear = 1'b0;
        #1;
        check("reset.therm", 32'(therm_out), 32'h0);
        check("reset.valid", 32'(out_valid), 32'h0);
        check("reset.ptr",   32'(ptr_out),   32'h0);
        @(negedge clk);
        reset = 1'b0;

        // static sweep F..0
        for (int c = 15; c >= 0; c--) begin
            step(1'b1, 4'(c), 1'b0, 1'b0, "sweep");
            check("sweep.const", 32'(therm_out), (32'd1 << (15 - c)) - 1);
        end

        // DWA wrap
        step(1'b0, 4'h0, 1'b1, 1'b1, "clr");
        step(1'b1, 4'hA, 1'b1, 1'b0, "dwa_a");
        check("dwa_a.const", 32'(therm_out), 32'h001F);
        check("dwa_a.ptr5",  32'(ptr_out),   32'd5);
        step(1'b1, 4'h3, 1'b1, 1'b0, "dwa_3");
        check("dwa_3.const", 32'(therm_out), 32'h7FE3);
        check("dwa_3.ptr2",  32'(ptr_out),   32'd2);

        // extremes at ptr 7
        step(1'b1, 4'hA, 1'b1, 1'b0, "to7");
        check("to7.ptr", 32'(ptr_out), 32'd7);
        step(1'b1, 4'h0, 1'b1, 1'b0, "kmax");
        check("kmax.const", 32'(therm_out), 32'h7FFF);
        check("kmax.ptr7",  32'(ptr_out),   32'd7);
        step(1'b1, 4'hF, 1'b1, 1'b0, "kzero");
        check("kzero.const", 32'(therm_out), 32'h0000);
        check("kzero.ptr7",  32'(ptr_out),   32'd7);

        // clear collision at ptr 9
        step(1'b1, 4'hD, 1'b1, 1'b0, "to9");
        check("to9.ptr", 32'(ptr_out), 32'd9);
        step(1'b1, 4'hC, 1'b1, 1'b1, "clrcol");
        check("clrcol.const", 32'(therm_out), 32'h0007);
        check("clrcol.ptr3",  32'(ptr_out),   32'd3);

        // hold
        hold_therm = therm_out;
        hold_ptr   = ptr_out;
        for (int h = 0; h < 3; h++) begin
            step(1'b0, 4'(h), 1'b1, 1'b0, "hold");
            check("hold.therm", 32'(therm_out), 32'(hold_therm));
            check("hold.ptr",   32'(ptr_out),   32'(hold_ptr));
        end

        // mode switch: static leaves pointer, static+clear zeroes it
        step(1'b1, 4'h9, 1'b0, 1'b0, "static_keep");
        check("static_keep.ptr3", 32'(ptr_out), 32'd3);
        step(1'b1, 4'h9, 1'b0, 1'b1, "static_clr");
        check("static_clr.ptr0", 32'(ptr_out), 32'd0);
        step(1'b1, 4'hB, 1'b1, 1'b0, "back_dwa");

        // randomized traffic
        for (int r = 0; r < 300; r++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 15) == 0), "rand");
        end

        // async reset mid-run with ptr 11 and a sample in flight
        step(1'b0, 4'h0, 1'b1, 1'b1, "clr2");
        step(1'b1, 4'h4, 1'b1, 1'b0, "to11");
        check("to11.ptr", 32'(ptr_out), 32'd11);
        @(negedge clk);
        in_valid  = 1'b1;
        binary_in = 4'h2;
        #2;
        reset = 1'b1;
        #1;
        check("areset.therm", 32'(therm_out), 32'h0);
        check("areset.valid", 32'(out_valid), 32'h0);
        check("areset.ptr",   32'(ptr_out),   32'h0);
        m_ptr = 0; m_therm = '0; m_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset.valid", 32'(out_valid), 32'h0);
        check("post_reset.therm", 32'(therm_out), 32'h0);
        step(1'b1, 4'hA, 1'b1, 1'b0, "first_after_reset");
        check("first_after_reset.const", 32'(therm_out), 32'h001F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
